// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial subtractor. It computes diff = a - b - bin (mod 2^WIDTH) one bit
//   per clock, LSB first, with a single full-subtractor cell and a one-bit
//   borrow register.
//
//   Handshake: start is sampled on a rising edge and accepted only while
//   busy=0 (IDLE or DONE). Once a start is accepted, busy stays high for WIDTH
//   cycles and start is ignored. done then pulses for exactly one cycle, and in
//   that cycle diff/bout hold the new result. diff/bout keep their value until
//   the next completion. A start seen during the DONE cycle begins a new
//   operation immediately, so continuous start gives one result per WIDTH+1
//   cycles.
//
//   Optional feature (macro SERIAL_SUB_SAT_EN): when the final borrow is 1,
//   diff is clamped to 0 at completion. bout still reports the borrow.
//
// Parameters
//   WIDTH     operand/result width in bits (2..32)
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     start request
//   a, b      minuend / subtrahend, captured on accepted start
//   bin       initial borrow-in, captured on accepted start
//   diff      registered result
//   bout      registered final borrow out
//   busy      high while an operation is in progress (RUN)
//   done      one-cycle completion pulse (DONE)
//   state_dbg current FSM state (IDLE=0, RUN=1, DONE=2) for observation
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    // Full-subtractor cell on the current LSBs.
    logic d_bit;
    logic br_nxt;
    assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB while the operand bits leave at the LSB, so after WIDTH
    // shifts the whole difference sits in it. The final bit has not been
    // shifted in yet at completion, so it is merged in directly.
    logic [WIDTH-1:0] res_full;
    assign res_full = {d_bit, a_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = res_full;
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d  = br_nxt ? '0 : res_full;
`else
                    diff_d  = res_full;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled on a rising clk edge.
REQ-005 a  input  WIDTH  minuend; captured only on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured only on an accepted start.
REQ-007 bin  input  1  initial borrow-in for bit 0; captured only on an accepted start.
REQ-008 diff  output  WIDTH  result a - b - bin modulo 2^WIDTH; registered.
REQ-009 bout  output  1  final borrow out of bit WIDTH-1; registered.
REQ-010 busy  output  1  high while a subtraction is in progress.
REQ-011 done  output  1  one-cycle pulse marking that diff/bout hold a new result.

Function
REQ-012 The block SHALL compute one bit per cycle, LSB first, with a full-subtractor cell (d = x^y^br; br' = (~x&y) | (~(x^y)&br)) and a one-bit borrow register.
REQ-013 FSM states SHALL be IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after the WIDTH-th bit; DONE->IDLE unconditionally after one cycle, or DONE->RUN when start=1 in DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE (busy=0); start in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-015 On accept: a and b SHALL load into internal shift registers, the borrow register SHALL load bin, and the bit counter SHALL clear to 0.
REQ-016 busy SHALL be 1 exactly in RUN: high from the edge after the accepting edge through the edge that processes bit WIDTH-1.
REQ-017 Latency: if start is accepted at edge k, done SHALL be 1 in the cycle after edge k+WIDTH and 0 in all other cycles.
REQ-018 diff and bout SHALL update only at edge k+WIDTH and SHALL hold their value until the next completion, including while busy.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap within one operation.
REQ-020 start held high continuously SHALL cause back-to-back operations with a period of WIDTH+1 cycles; operands SHALL be resampled at each DONE cycle.

Reset
REQ-021 When rst_n=0, independent of clk: state=IDLE, counter=0, borrow register=0, shift registers=0, diff=0, bout=0, busy=0, done=0.
REQ-022 Reset during RUN SHALL abort the operation with no done pulse, leaving the reset values of REQ-021 on diff and bout.
REQ-023 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro SERIAL_SUB_SAT_EN, when defined, SHALL force diff to 0 at completion whenever the final borrow is 1; bout SHALL still report 1.
REQ-025 Without SERIAL_SUB_SAT_EN, diff SHALL be the raw modulo-2^WIDTH result; all timing is identical in both builds.

Verification (WIDTH=8)
REQ-026 a=0x35, b=0x12, bin=0, start pulse -> busy high for 8 cycles, then done=1 for 1 cycle with diff=0x23, bout=0.
REQ-027 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; with SERIAL_SUB_SAT_EN -> diff=0x00, bout=1.
REQ-028 a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
REQ-029 start pulsed again with a=0x01 at cycle 3 of a RUN on 0x35-0x12 -> ignored; result stays 0x23, and exactly one done occurs.
REQ-030 rst_n low at cycle 4 of RUN -> busy=0, done never pulses, diff=0x00, bout=0; the next start yields a correct result.
REQ-031 start held high with operands changing at each DONE cycle -> done every 9 cycles, each result matching the operands sampled at its accept.
